// File: rtl/decode_div_70s_33s_40_seq.sv
// ============================================================================
// decode_div_70s_33s_40_seq
//
// Sequential signed divider for the decoder path. Divides a signed dividend
// (din0) by a signed divisor (din1) with a restoring algorithm on magnitudes.
// It produces one quotient bit per enabled cycle and then applies the signs
// and saturates in a final fix-up cycle. The quotient truncates toward zero
// and saturates to the dout range.
//
// Optional feature: define DECODE_DIV_REM_EN to expose the signed remainder
// on the rem port. The remainder carries the dividend's sign. Without the
// macro the rem port and its output register do not exist.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ce         clock enable; low freezes every register and every handshake
//   in_valid   din0/din1 valid
//   in_ready   block idle and able to accept an operand pair
//   din0       signed dividend  (din0_WIDTH)
//   din1       signed divisor   (din1_WIDTH)
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   dout       signed quotient, truncated toward zero and saturated
//   ovf        quotient was saturated because it is out of range
//   dz         divisor was zero
//   rem        signed remainder (only with DECODE_DIV_REM_EN)
// ============================================================================
module decode_div_70s_33s_40_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 70,
   parameter int din1_WIDTH = 33,
   parameter int dout_WIDTH = 40
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf,
   output logic                  dz
`ifdef DECODE_DIV_REM_EN
   ,
   output logic [din1_WIDTH-1:0] rem
`endif
);

   localparam int CNT_W = $clog2(din0_WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
   localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

   logic [1:0]            state_q, state_d;
   logic [din0_WIDTH-1:0] a_q, a_d;        // dividend magnitude, shifted out MSB first
   logic [din1_WIDTH-1:0] b_q, b_d;        // divisor magnitude (|-2^32| still fits)
   logic [din0_WIDTH-1:0] q_q, q_d;        // quotient magnitude shift register
   logic [din1_WIDTH-1:0] r_q, r_d;        // partial remainder magnitude, always < |din1|
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  qsign_q, qsign_d;
   logic                  dsign_q, dsign_d;
   logic [dout_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic                  dz_q, dz_d;
`ifdef DECODE_DIV_REM_EN
   logic [din1_WIDTH-1:0] rem_q, rem_d;
`endif

   // Datapath helpers
   logic [din1_WIDTH:0]   r_shift;         // partial remainder after shifting in one bit
   logic                  r_ge;
   logic [din1_WIDTH-1:0] r_sub;
   logic                  q_big_pos;
   logic                  q_big_neg;
   logic [dout_WIDTH-1:0] q_low;

   assign r_shift = {r_q, a_q[din0_WIDTH-1]};
   assign r_ge    = (r_shift >= {1'b0, b_q});
   // When the trial subtraction succeeds the difference is below |din1|, so a
   // subtraction truncated to the divisor width is exact.
   assign r_sub   = r_shift[din1_WIDTH-1:0] - b_q;

   // A positive quotient fits only below 2^(W-1); a negative one may reach
   // exactly 2^(W-1) in magnitude.
   assign q_big_pos = |q_q[din0_WIDTH-1:dout_WIDTH-1];
   assign q_big_neg = (|q_q[din0_WIDTH-1:dout_WIDTH])
                    | (q_q[dout_WIDTH-1] & (|q_q[dout_WIDTH-2:0]));
   assign q_low     = q_q[dout_WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      qsign_d = qsign_q;
      dsign_d = dsign_q;
      dout_d  = dout_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
`ifdef DECODE_DIV_REM_EN
      rem_d   = rem_q;
`endif
      if (ce) begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_d     = din0[din0_WIDTH-1] ? -din0 : din0;
                  b_d     = din1[din1_WIDTH-1] ? -din1 : din1;
                  dsign_d = din0[din0_WIDTH-1];
                  qsign_d = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                  q_d     = '0;
                  r_d     = '0;
                  cnt_d   = CNT_W'(din0_WIDTH - 1);
                  state_d = (din1 == '0) ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               a_d = {a_q[din0_WIDTH-2:0], 1'b0};
               q_d = {q_q[din0_WIDTH-2:0], r_ge};
               r_d = r_ge ? r_sub : r_shift[din1_WIDTH-1:0];
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_FIX: begin
               if (b_q == '0) begin
                  dz_d   = 1'b1;
                  ovf_d  = 1'b0;
                  dout_d = dsign_q ? Q_MIN : Q_MAX;
               end else begin
                  dz_d = 1'b0;
                  if (!qsign_q && q_big_pos) begin
                     ovf_d  = 1'b1;
                     dout_d = Q_MAX;
                  end else if (qsign_q && q_big_neg) begin
                     ovf_d  = 1'b1;
                     dout_d = Q_MIN;
                  end else begin
                     ovf_d  = 1'b0;
                     dout_d = qsign_q ? -q_low : q_low;
                  end
               end
`ifdef DECODE_DIV_REM_EN
               if (b_q == '0) begin
                  rem_d = '0;
               end else begin
                  rem_d = dsign_q ? -r_q : r_q;
               end
`endif
               state_d = S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         qsign_q <= 1'b0;
         dsign_q <= 1'b0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
`ifdef DECODE_DIV_REM_EN
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         qsign_q <= qsign_d;
         dsign_q <= dsign_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
`ifdef DECODE_DIV_REM_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign dout      = dout_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;
`ifdef DECODE_DIV_REM_EN
   assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_decode_div_70s_33s_40_seq.sv
// ============================================================================
// tb_decode_div_70s_33s_40_seq
//
// Directed bench for the sequential signed divider. Expected results come
// from a plain-arithmetic model (wide signed / and %, then saturation); a few
// literal results pin the model. One compare process checks the outputs on
// every cycle the result is valid, and the driver checks latencies, the
// back-pressure hold and reset behaviour.
// ============================================================================
module tb_decode_div_70s_33s_40_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [69:0] din0;
   logic [32:0] din1;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] dout;
   logic        ovf;
   logic        dz;
`ifdef DECODE_DIV_REM_EN
   logic [32:0] rem;
`endif

   decode_div_70s_33s_40_seq #(
      .ID(1), .din0_WIDTH(70), .din1_WIDTH(33), .dout_WIDTH(40)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .ce(ce),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .din0(din0),
      .din1(din1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dout(dout),
      .ovf(ovf),
      .dz(dz)
`ifdef DECODE_DIV_REM_EN
      ,
      .rem(rem)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [39:0] q;
      logic [32:0] r;
      logic        ovf;
      logic        dz;
   } res_t;

   res_t exp_res;

   // Reference: exact signed division, truncation toward zero, then
   // saturation to the 40-bit signed range.
   function automatic res_t model(input logic signed [69:0] a, input logic signed [32:0] b);
      logic signed [127:0] aa, bb, qq, rr, hi, lo;
      res_t res;
      aa  = a;
      bb  = b;
      hi  = (128'sd1 <<< 39) - 128'sd1;
      lo  = -(128'sd1 <<< 39);
      res = '0;
      if (bb == 0) begin
         res.dz = 1'b1;
         res.q  = (aa < 0) ? 40'h80_0000_0000 : 40'h7F_FFFF_FFFF;
      end else begin
         qq    = aa / bb;
         rr    = aa % bb;
         res.r = rr[32:0];
         if (qq > hi) begin
            res.q = 40'h7F_FFFF_FFFF;
            res.ovf = 1'b1;
         end else if (qq < lo) begin
            res.q = 40'h80_0000_0000;
            res.ovf = 1'b1;
         end else begin
            res.q = qq[39:0];
         end
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: handshake exclusivity every cycle, result every valid cycle.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("ready_and_valid", {127'd0, in_ready & out_valid}, 128'd0);
         if (out_valid === 1'b1) begin
            chk("dout", {88'd0, dout}, {88'd0, exp_res.q});
            chk("ovf", {127'd0, ovf}, {127'd0, exp_res.ovf});
            chk("dz", {127'd0, dz}, {127'd0, exp_res.dz});
`ifdef DECODE_DIV_REM_EN
            chk("rem", {95'd0, rem}, {95'd0, exp_res.r});
`endif
         end
      end
   end

   // Waits for in_ready, presents the operands and completes the input transfer.
   task automatic start_div(input logic [69:0] a, input logic [32:0] b);
      int guard;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      if (in_ready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL start_timeout: in_ready=%b expected 1", in_ready);
      end
      exp_res  = model(a, b);
      din0     = a;
      din1     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts edges from acceptance (inclusive) until out_valid, optionally
   // dropping ce, then holds out_ready low for bp cycles before accepting.
   task automatic finish_div(input string tag, input int stall_at, input int stall_len,
                             input int bp, input int exp_lat);
      int lat;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 400) begin
         if (lat == stall_at) ce = 1'b0;
         if (lat == stall_at + stall_len) ce = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      ce = 1'b1;
      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk({tag, "_bp_in_ready"}, {127'd0, in_ready}, 128'd0);
         chk({tag, "_bp_out_valid"}, {127'd0, out_valid}, 128'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_released"}, {126'd0, out_valid, in_ready}, 128'd1);
      $display("vector %s: din0=%0h din1=%0h dout=%0h ovf=%0b dz=%0b latency=%0d",
               tag, din0, din1, dout, ovf, dz, lat);
   endtask

   task automatic run_div(input string tag, input logic [69:0] a, input logic [32:0] b,
                          input int exp_lat);
      start_div(a, b);
      finish_div(tag, 0, 0, 0, exp_lat);
   endtask

   res_t m;

   initial begin
      reset_n   = 1'b0;
      ce        = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din0      = '0;
      din1      = '0;
      exp_res   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_dout", {88'd0, dout}, 128'd0);
      chk("rst_flags", {126'd0, ovf, dz}, 128'd0);
      reset_n = 1'b1;

      // Literal pins on the model
      m = model(70'sd1000, 33'sd7);
      chk("model_pos_q", {88'd0, m.q}, 128'd142);
      chk("model_pos_r", {95'd0, m.r}, 128'd6);
      m = model(-70'sd1000, 33'sd7);
      chk("model_neg_q", {88'd0, m.q}, {88'd0, 40'hFF_FFFF_FF72});
      chk("model_neg_r", {95'd0, m.r}, {95'd0, 33'h1_FFFF_FFFA});
      m = model(70'sd1 <<< 60, 33'sd3);
      chk("model_ovf", {87'd0, m.q, m.ovf}, {87'd0, 40'h7F_FFFF_FFFF, 1'b1});
      m = model(-(70'sd1 <<< 39), 33'sd1);
      chk("model_min", {87'd0, m.q, m.ovf}, {87'd0, 40'h80_0000_0000, 1'b0});
      m = model(70'sd5, 33'sd0);
      chk("model_dz", {87'd0, m.q, m.dz}, {87'd0, 40'h7F_FFFF_FFFF, 1'b1});

      @(posedge clk); #1;

      run_div("pos",       70'sd1000,               33'sd7,  72);
      run_div("neg_dvd",   -70'sd1000,              33'sd7,  72);
      run_div("neg_dvs",   70'sd1000,               -33'sd7, 72);
      run_div("ovf_pos",   70'sd1 <<< 60,           33'sd3,  72);
      run_div("ovf_min",   70'sd1 <<< 69,           -33'sd1, 72);
      run_div("min_ok",    -(70'sd1 <<< 39),        33'sd1,  72);
      run_div("max_ok",    70'sd1649267441663,      33'sd3,  72);
      run_div("ovf_edge",  70'sd1 <<< 39,           33'sd1,  72);
      run_div("ovf_neg",   -(70'sd1 <<< 39) - 70'sd1, 33'sd1, 72);
      run_div("big_dvs",   70'sd1 <<< 50,           33'sd1 <<< 32, 72);
      run_div("zero",      70'sd0,                  33'sd5,  72);
      run_div("minus_one", -70'sd7,                 33'sd7,  72);
      run_div("dz_pos",    70'sd5,                  33'sd0,  2);
      run_div("dz_neg",    -70'sd5,                 33'sd0,  2);

      // ce dropped for 10 cycles mid-CALC
      start_div(70'sd1000, 33'sd7);
      finish_div("stall", 30, 10, 0, 82);

      // 20 cycles of back-pressure in DONE
      start_div(-70'sd123456789, 33'sd1000);
      finish_div("backpressure", 0, 0, 20, 72);

      // Asynchronous reset in the middle of CALC
      start_div(70'sd999999, 33'sd3);
      repeat (30) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("midrst_dout", {88'd0, dout}, 128'd0);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_div("after_rst", 70'sd1000, 33'sd7, 72);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
